// File: rtl/riscv_seq_divider_if.sv
// Request/response bundle between the ID stage and the sequential divider.
// The master drives the operands and request; the slave returns result, ready and stall.
interface riscv_seq_divider_if;
  logic        id_div_req_r;
  logic        id_div_signed_r;
  logic        id_div_rem_r;
  logic [31:0] id_ra_value_r;
  logic [31:0] id_rb_value_r;
  logic [31:0] div_res_r;
  logic        div_ready_r;
  logic        ex_stall_div_w;

  modport master (
    output id_div_req_r, id_div_signed_r, id_div_rem_r, id_ra_value_r, id_rb_value_r,
    input  div_res_r, div_ready_r, ex_stall_div_w
  );

  modport slave (
    input  id_div_req_r, id_div_signed_r, id_div_rem_r, id_ra_value_r, id_rb_value_r,
    output div_res_r, div_ready_r, ex_stall_div_w
  );
endinterface

// File: rtl/riscv_seq_divider.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle without stalling.
module riscv_seq_divider (
  input  logic                      clk_i,
  input  logic                      rst_i,
  riscv_seq_divider_if.slave        div_if
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_rem_sel;
  logic [31:0] r_res;
  logic        r_ready;

  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic [31:0] w_result;
  logic        w_ra_neg;
  logic        w_rb_neg;
  logic [31:0] w_ra_mag;
  logic [31:0] w_rb_mag;
  logic        w_div_zero;
  logic        w_overflow;

  // The partial remainder is always below the divisor, so 32 bits of storage suffice;
  // the shifted-in dividend bit widens the trial subtraction to 33 bits.
  always_comb begin
    w_shift     = {r_rem, r_dividend[31]};
    w_trial     = w_shift - {1'b0, r_divisor};
    w_qbit      = ~w_trial[32];
    w_rem_next  = w_qbit ? w_trial[31:0] : w_shift[31:0];
    w_quot_next = {r_quot[30:0], w_qbit};
    if (r_rem_sel) begin
      w_result = r_neg_r ? (32'd0 - w_rem_next) : w_rem_next;
    end else begin
      w_result = r_neg_q ? (32'd0 - w_quot_next) : w_quot_next;
    end
  end

  always_comb begin
    w_ra_neg   = div_if.id_div_signed_r & div_if.id_ra_value_r[31];
    w_rb_neg   = div_if.id_div_signed_r & div_if.id_rb_value_r[31];
    w_ra_mag   = w_ra_neg ? (32'd0 - div_if.id_ra_value_r) : div_if.id_ra_value_r;
    w_rb_mag   = w_rb_neg ? (32'd0 - div_if.id_rb_value_r) : div_if.id_rb_value_r;
    w_div_zero = (div_if.id_rb_value_r == 32'd0);
    w_overflow = div_if.id_div_signed_r &&
                 (div_if.id_ra_value_r == 32'h8000_0000) &&
                 (div_if.id_rb_value_r == 32'hFFFF_FFFF);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_count    <= 5'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_rem      <= 32'd0;
      r_quot     <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_rem_sel  <= 1'b0;
      r_res      <= 32'd0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (div_if.id_div_req_r) begin
            r_rem_sel <= div_if.id_div_rem_r;
            r_neg_q   <= w_ra_neg ^ w_rb_neg;
            r_neg_r   <= w_ra_neg;
            if (w_div_zero) begin
              r_res   <= div_if.id_div_rem_r ? div_if.id_ra_value_r : 32'hFFFF_FFFF;
              r_ready <= 1'b1;
              r_state <= DONE;
            end else if (w_overflow) begin
              r_res   <= div_if.id_div_rem_r ? 32'd0 : 32'h8000_0000;
              r_ready <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dividend <= w_ra_mag;
              r_divisor  <= w_rb_mag;
              r_rem      <= 32'd0;
              r_quot     <= 32'd0;
              r_count    <= 5'd31;
              r_state    <= BUSY;
            end
          end
        end
        BUSY: begin
          r_rem      <= w_rem_next;
          r_quot     <= w_quot_next;
          r_dividend <= {r_dividend[30:0], 1'b0};
          if (r_count == 5'd0) begin
            r_res   <= w_result;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_count <= r_count - 5'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign div_if.div_res_r      = r_res;
  assign div_if.div_ready_r    = r_ready;
  assign div_if.ex_stall_div_w = (r_state == BUSY);

endmodule
